// File: rtl/mem_port_arbiter_if.sv
// Cache-to-memory port bundle: two requesters, one downstream line-wide port.
// slave = arbiter side, master = caches plus memory model side.
interface mem_port_arbiter_if #(
    parameter int ADDRESSBITS = 32,
    parameter int LINEBITS    = 256
);
    logic                   rd0;
    logic                   wr0;
    logic [ADDRESSBITS-1:0] addr0;
    logic [LINEBITS-1:0]    wdata0;
    logic                   acc0;
    logic                   rd1;
    logic                   wr1;
    logic [ADDRESSBITS-1:0] addr1;
    logic [LINEBITS-1:0]    wdata1;
    logic                   acc1;
    logic [LINEBITS-1:0]    rdata;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDRESSBITS-1:0] mem_address;
    logic [LINEBITS-1:0]    mem_wdata;
    logic [LINEBITS-1:0]    mem_rdata;
    logic                   mem_accepted;
    logic                   timeout_err;

    modport slave (
        input  rd0, wr0, addr0, wdata0, rd1, wr1, addr1, wdata1,
               mem_rdata, mem_accepted,
        output acc0, acc1, rdata, mem_read, mem_write, mem_address,
               mem_wdata, timeout_err
    );

    modport master (
        output rd0, wr0, addr0, wdata0, rd1, wr1, addr1, wdata1,
               mem_rdata, mem_accepted,
        input  acc0, acc1, rdata, mem_read, mem_write, mem_address,
               mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache (0) and D-cache (1).
// One arbitration cycle, then the granted port passes straight through until accepted.
module mem_port_arbiter #(
    parameter int ADDRESSBITS = 32,
    parameter int LINEBITS    = 256,
    parameter int TIMEOUT     = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNTW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic                   req0, req1;
    logic                   gnt_port;
    logic                   gnt_req;
    logic                   gnt_acc;
    logic                   sel_rd, sel_wr;
    logic [ADDRESSBITS-1:0] sel_addr;
    logic [LINEBITS-1:0]    sel_wdata;

    assign req0 = bus.rd0 | bus.wr0;
    assign req1 = bus.rd1 | bus.wr1;

    // Downstream path: only the granted port is visible, everything zero otherwise.
    always_comb begin
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        bus.acc0  = 1'b0;
        bus.acc1  = 1'b0;
        case (state_q)
            GNT0: begin
                sel_rd    = bus.rd0 & ~bus.wr0;
                sel_wr    = bus.wr0;
                sel_addr  = bus.addr0;
                sel_wdata = bus.wdata0;
                bus.acc0  = bus.mem_accepted & req0;
            end
            GNT1: begin
                sel_rd    = bus.rd1 & ~bus.wr1;
                sel_wr    = bus.wr1;
                sel_addr  = bus.addr1;
                sel_wdata = bus.wdata1;
                bus.acc1  = bus.mem_accepted & req1;
            end
            default: ;
        endcase
    end

    assign bus.mem_read    = sel_rd;
    assign bus.mem_write   = sel_wr;
    assign bus.mem_address = sel_addr;
    assign bus.mem_wdata   = sel_wdata;
    assign bus.rdata       = bus.mem_rdata;
    assign bus.timeout_err = timeout_err_q;

    assign gnt_port = (state_q == GNT1);
    assign gnt_req  = gnt_port ? req1 : req0;
    assign gnt_acc  = gnt_port ? bus.acc1 : bus.acc0;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!gnt_req) begin
                    // Requester withdrew (flush/reset): fairness history untouched.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (gnt_acc) begin
                    state_d      = IDLE;
                    last_grant_d = gnt_port;
                    wait_cnt_d   = '0;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    last_grant_d  = gnt_port;
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4; inputs driven 1ns after posedge.
module tb_mem_port_arbiter;
    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_fail;
    int   n0, n1;
    bit   exp_port;

    localparam logic [31:0]  A0 = 32'h0000_1000;
    localparam logic [31:0]  A1 = 32'h0000_2040;
    localparam logic [31:0]  A2 = 32'h0000_3080;
    localparam logic [31:0]  A3 = 32'h0000_40C0;
    localparam logic [31:0]  A4 = 32'h0000_5100;
    localparam logic [255:0] W1 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] W2 = {8{32'h1234_5678}};
    localparam logic [255:0] RD = {4{64'hA5A5_0F0F_3C3C_9696}};

    mem_port_arbiter_if #(.ADDRESSBITS(32), .LINEBITS(256)) bus ();

    mem_port_arbiter #(.ADDRESSBITS(32), .LINEBITS(256), .TIMEOUT(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET = 1'b0;
        bus.rd0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.rd1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_rdata = '0; bus.mem_accepted = 0;
        #12;
        check("rst_mem_read",  256'(bus.mem_read), 0);
        check("rst_mem_write", 256'(bus.mem_write), 0);
        check("rst_mem_addr",  256'(bus.mem_address), 0);
        check("rst_acc",       256'({bus.acc0, bus.acc1}), 0);
        check("rst_terr",      256'(bus.timeout_err), 0);
        #1 RESET = 1'b1;

        // 1: single read from port 0, accepted on the third grant cycle
        tick();
        bus.rd0 = 1; bus.addr0 = A0;
        #1 check("t1_arb_cycle", 256'(bus.mem_read), 0);
        tick();
        check("t1_g1_read", 256'(bus.mem_read), 1);
        check("t1_g1_addr", 256'(bus.mem_address), 256'(A0));
        check("t1_g1_acc0", 256'(bus.acc0), 0);
        tick();
        check("t1_g2_read", 256'(bus.mem_read), 1);
        tick();
        bus.mem_accepted = 1; bus.mem_rdata = RD;
        #1 check("t1_acc0", 256'(bus.acc0), 1);
        check("t1_acc1", 256'(bus.acc1), 0);
        check("t1_rdata", bus.rdata, RD);
        tick();
        bus.rd0 = 0;
        #1 check("t1_idle_acc0", 256'(bus.acc0), 0);
        check("t1_idle_read", 256'(bus.mem_read), 0);
        bus.mem_accepted = 0;

        // 2: simultaneous rd0/wr1 after reset -> port 0, then 1, then 0
        #1 RESET = 1'b0;
        #1 RESET = 1'b1;
        bus.rd0 = 1; bus.addr0 = A0;
        bus.wr1 = 1; bus.addr1 = A1; bus.wdata1 = W1;
        #1 check("t2_arb", 256'({bus.mem_read, bus.mem_write}), 0);
        tick();
        check("t2_g0_rw",   256'({bus.mem_read, bus.mem_write}), 256'(2'b10));
        check("t2_g0_addr", 256'(bus.mem_address), 256'(A0));
        bus.mem_accepted = 1;
        #1 check("t2_g0_acc", 256'({bus.acc0, bus.acc1}), 256'(2'b10));
        tick();
        bus.rd0 = 0; bus.mem_accepted = 0;
        #1 check("t2_idle_write", 256'(bus.mem_write), 0);
        tick();
        check("t2_g1_rw",    256'({bus.mem_read, bus.mem_write}), 256'(2'b01));
        check("t2_g1_addr",  256'(bus.mem_address), 256'(A1));
        check("t2_g1_wdata", bus.mem_wdata, W1);
        bus.mem_accepted = 1;
        #1 check("t2_g1_acc", 256'({bus.acc0, bus.acc1}), 256'(2'b01));
        tick();
        bus.mem_accepted = 0; bus.rd0 = 1;
        #1 check("t2_idle2", 256'({bus.mem_read, bus.mem_write}), 0);
        tick();
        check("t2_rr_port0", 256'({bus.mem_read, bus.mem_write}), 256'(2'b10));
        bus.mem_accepted = 1;
        #1 check("t2_rr_acc", 256'({bus.acc0, bus.acc1}), 256'(2'b10));
        tick();
        bus.rd0 = 0; bus.wr1 = 0; bus.mem_accepted = 0;

        // 3: both ports read continuously, memory always accepting; last winner was 0
        tick();
        bus.rd0 = 1; bus.rd1 = 1; bus.addr0 = A0; bus.addr1 = A1; bus.mem_accepted = 1;
        #1 check("t3_arb", 256'({bus.acc0, bus.acc1}), 0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            exp_port = (i % 2 == 0);
            tick();
            check($sformatf("t3_acc_%0d", i), 256'({bus.acc0, bus.acc1}),
                  exp_port ? 256'(2'b01) : 256'(2'b10));
            check($sformatf("t3_addr_%0d", i), 256'(bus.mem_address),
                  exp_port ? 256'(A1) : 256'(A0));
            n0 += int'(bus.acc0);
            n1 += int'(bus.acc1);
            tick();
        end
        check("t3_n0", 256'(n0), 10);
        check("t3_n1", 256'(n1), 10);
        bus.rd0 = 0; bus.rd1 = 0; bus.mem_accepted = 0;

        // 4: port 1 write withdrawn before acceptance
        tick();
        bus.wr1 = 1; bus.addr1 = A2; bus.wdata1 = W2;
        tick();
        check("t4_g_write", 256'(bus.mem_write), 1);
        check("t4_g_wdata", bus.mem_wdata, W2);
        tick();
        bus.wr1 = 0;
        #1 check("t4_drop_write", 256'(bus.mem_write), 0);
        check("t4_drop_acc", 256'(bus.acc1), 0);
        tick();
        bus.wr1 = 1; bus.mem_accepted = 1;
        #1 check("t4_idle_acc1", 256'(bus.acc1), 0);
        check("t4_idle_write", 256'(bus.mem_write), 0);
        tick();
        bus.wr1 = 0; bus.mem_accepted = 0;
        tick();

        // 5: port 0 read never accepted -> abort after 4 grant cycles, port 1 next
        bus.rd0 = 1; bus.addr0 = A3;
        tick();
        bus.rd1 = 1; bus.addr1 = A4;
        #1 check("t5_g1_read", 256'(bus.mem_read), 1);
        check("t5_g1_addr", 256'(bus.mem_address), 256'(A3));
        check("t5_g1_terr", 256'(bus.timeout_err), 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("t5_g%0d_addr", k), 256'(bus.mem_address), 256'(A3));
        end
        tick();
        check("t5_abort_read", 256'(bus.mem_read), 0);
        check("t5_abort_terr", 256'(bus.timeout_err), 1);
        tick();
        check("t5_next_addr", 256'(bus.mem_address), 256'(A4));
        check("t5_next_read", 256'(bus.mem_read), 1);
        bus.mem_accepted = 1;
        #1 check("t5_next_acc", 256'({bus.acc0, bus.acc1}), 256'(2'b01));
        tick();
        bus.rd0 = 0; bus.rd1 = 0; bus.mem_accepted = 0;
        #1 check("t5_terr_sticky", 256'(bus.timeout_err), 1);

        // 6: reset asserted mid-grant to port 1
        tick();
        bus.wr1 = 1; bus.addr1 = A2; bus.wdata1 = W2;
        tick();
        check("t6_g_write", 256'(bus.mem_write), 1);
        bus.mem_accepted = 1;
        #1 RESET = 1'b0;
        #1 check("t6_rst_write", 256'(bus.mem_write), 0);
        check("t6_rst_addr",  256'(bus.mem_address), 0);
        check("t6_rst_wdata", bus.mem_wdata, 0);
        check("t6_rst_acc1",  256'(bus.acc1), 0);
        check("t6_rst_terr",  256'(bus.timeout_err), 0);
        #1 RESET = 1'b1;
        #1 check("t6_post_idle", 256'({bus.mem_write, bus.acc1}), 0);
        bus.wr1 = 0; bus.mem_accepted = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
